// File: rtl/pipe_stage_skid.sv
// Purpose : inter-stage pipeline register with a two-entry skid buffer, flush and perf counters.
// Latency : one cycle from push to out_* when empty (or one entry popping in the same cycle).
// Backpr. : in_ready is a flop, low only while both entries are held; no comb ready path upstream.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   flush                     squash every held entry and any same-cycle input
//   in_valid/in_ready         upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready       downstream handshake, out_ctrl/out_data payload (zero when idle)
//   occupancy                 held entries (0..2)
//   stall_cnt, flush_cnt      saturating performance counters
module pipe_stage_skid #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   push, pop;
    entry_t in_ent;

    assign in_ent = '{ctrl: in_ctrl, data: in_data};
    assign push   = in_valid & in_ready_q;
    assign pop    = (state_q != EMPTY) & out_ready;

    // State register (FSM state, storage, registered ready).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic. Storage is zeroed whenever an entry leaves so that
    // out_ctrl/out_data read as the bubble encoding while idle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_ent;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_ent;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_ent;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        // Ready is computed from the next state so it can be a plain flop.
        in_ready_d = (state_d != FULL);
    end

    // Output logic: everything is taken straight from registers.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_ctrl  = main_q.ctrl;
        out_data  = main_q.data;
        occupancy = state_q;
        in_ready  = in_ready_q;
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && ((state_q != EMPTY) || push) && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Purpose : self-checking bench for pipe_stage_skid against a queue-based reference model.
// Latency : model advances once per rising edge; outputs compared 1 time unit after the edge.
// Backpr. : randomized out_ready/in_valid/flush; a second small-counter instance covers saturation.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [63:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // Small-counter instance for saturation.
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_ctrl;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_ctrl;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(8), .CNT_W(4)) sat_dut (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic [15:0] c;
        logic [63:0] d;
    } ent_t;

    ent_t q[$];
    int   m_stall;
    int   m_flush;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("out_ctrl",  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
        check("out_data",  out_data,       (q.size() > 0) ? q[0].d : 64'd0);
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    endtask

    // One clock: the model consumes the inputs that were stable across the edge.
    task automatic tick();
        bit   mpush, mpop;
        ent_t e;
        @(posedge clk);
        mpush = in_valid && (q.size() < 2);
        mpop  = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
        if (flush && ((q.size() != 0) || mpush) && (m_flush < 65535)) m_flush++;
        if (flush) begin
            q.delete();
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                e.c = in_ctrl;
                e.d = in_data;
                q.push_back(e);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [63:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 64'h0);
        s_in_valid = 1'b0; s_in_ctrl = 8'h0; s_in_data = 8'h0; s_out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare_all();

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 64'(i * 16));
            tick();
            check("stream_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
        end
        drive(1'b0, 16'h0, 64'h0);
        tick();
        tick();

        // Back-pressure: A then B held for 4 stalled cycles.
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 64'hA0A0);
        tick();
        drive(1'b1, 16'h00BB, 64'hB0B0);
        tick();
        drive(1'b0, 16'h0, 64'h0);
        tick();
        tick();
        tick();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_occ",      64'(occupancy), 64'd2);
        check("bp_stall",    64'(stall_cnt), 64'd4);
        check("bp_head_a",   64'(out_ctrl), 64'h00AA);
        out_ready = 1'b1;
        tick();
        check("bp_second_b", 64'(out_ctrl), 64'h00BB);
        tick();
        check("bp_drained",  64'(out_valid), 64'd0);

        // Flush while full, with C offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 16'h00DD, 64'hD0D0);
        tick();
        drive(1'b1, 16'h00EE, 64'hE0E0);
        tick();
        drive(1'b1, 16'h00CC, 64'hC0C0);
        flush = 1'b1;
        tick();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_cnt",   64'(flush_cnt), 64'd1);
        flush = 1'b0;
        drive(1'b0, 16'h0, 64'h0);
        tick();
        check("fl_c_absent", 64'(out_valid), 64'd0);
        flush = 1'b1;
        tick();
        check("fl_empty_nocount", 64'(flush_cnt), 64'd1);
        flush = 1'b0;

        // Asynchronous reset mid-cycle while full.
        drive(1'b1, 16'h0011, 64'h1111);
        tick();
        drive(1'b1, 16'h0022, 64'h2222);
        tick();
        drive(1'b0, 16'h0, 64'h0);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl",  64'(out_ctrl),  64'd0);
        check("arst_data",  out_data,       64'd0);
        check("arst_ready", 64'(in_ready),  64'd1);
        check("arst_occ",   64'(occupancy), 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        check("arst_flush", 64'(flush_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        compare_all();

        // Saturation on the 4-bit counter instance: one entry held for 20+ cycles.
        s_in_valid = 1'b1; s_in_ctrl = 8'h5A; s_in_data = 8'hA5;
        tick();
        s_in_valid = 1'b0;
        repeat (20) tick();
        check("sat_valid", 64'(s_out_valid), 64'd1);
        check("sat_ctrl",  64'(s_out_ctrl),  64'h5A);
        check("sat_stall", 64'(s_stall_cnt), 64'd15);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(99) < 60), 16'($urandom), {$urandom, $urandom});
            out_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 5);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
